// File: rtl/fsmlevel.sv
// Eight-level need-satisfaction ladder: a Moore FSM that climbs L0..L7 as each
// stage's governing need input reaches the satisfaction threshold.
module fsmlevel (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] NH,
  input  logic [2:0] NS,
  input  logic [2:0] NF,
  input  logic [2:0] NE,
  output logic [2:0] state
);

  localparam logic [2:0] Threshold = 3'd3;

  typedef enum logic [2:0] {
    StL0 = 3'd0,
    StL1 = 3'd1,
    StL2 = 3'd2,
    StL3 = 3'd3,
    StL4 = 3'd4,
    StL5 = 3'd5,
    StL6 = 3'd6,
    StL7 = 3'd7
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic w_nh_ok;
  logic w_ns_ok;
  logic w_nf_ok;
  logic w_ne_ok;

  assign w_nh_ok = (NH >= Threshold);
  assign w_ns_ok = (NS >= Threshold);
  assign w_nf_ok = (NF >= Threshold);
  assign w_ne_ok = (NE >= Threshold);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StL0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Odd levels are transient confirmations: the need must still be met one
  // cycle later, otherwise the ladder falls back to the preceding even level.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StL0:    w_state_next = w_nh_ok ? StL1 : StL0;
      StL1:    w_state_next = w_nh_ok ? StL2 : StL0;
      StL2:    w_state_next = w_ns_ok ? StL3 : StL2;
      StL3:    w_state_next = w_ns_ok ? StL4 : StL2;
      StL4:    w_state_next = w_nf_ok ? StL5 : StL4;
      StL5:    w_state_next = w_nf_ok ? StL6 : StL4;
      StL6:    w_state_next = w_ne_ok ? StL7 : StL6;
      StL7:    w_state_next = StL7;
      default: w_state_next = StL0;
    endcase
  end

  always_comb begin
    state = r_state;
  end

endmodule

// File: tb/tb_fsmlevel.sv
// Directed bench for fsmlevel: expected levels are queued as stimulus is applied
// and popped against the DUT output one time unit after each rising edge.
module tb_fsmlevel;

  logic       clk;
  logic       reset;
  logic [2:0] NH;
  logic [2:0] NS;
  logic [2:0] NF;
  logic [2:0] NE;
  logic [2:0] state;

  logic [2:0] exp_q[$];
  int         n_tests;
  int         n_fail;

  fsmlevel dut (
    .clk  (clk),
    .reset(reset),
    .NH   (NH),
    .NS   (NS),
    .NF   (NF),
    .NE   (NE),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag);
    logic [2:0] exp;
    exp = exp_q.pop_front();
    n_tests++;
    assert (state === exp) else begin
      n_fail++;
      $error("FAIL %s: state=%0d expected=%0d", tag, state, exp);
    end
  endtask

  // Compare immediately, no clock edge.
  task automatic check_now(input logic [2:0] exp, input string tag);
    exp_q.push_back(exp);
    compare(tag);
  endtask

  // Advance one rising edge, then compare the registered level.
  task automatic tick(input logic [2:0] exp, input string tag);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic drive(input logic [2:0] h, input logic [2:0] s,
                       input logic [2:0] f, input logic [2:0] e);
    NH = h;
    NS = s;
    NF = f;
    NE = e;
  endtask

  // Asynchronous reset pulse taken between edges; level must clear before any edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check_now(3'd0, tag);
    tick(3'd0, {tag, "_held"});
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    drive(3'd0, 3'd0, 3'd0, 3'd0);

    // Reset with all inputs zero, then idle for 5 cycles.
    #2;
    check_now(3'd0, "reset_async");
    tick(3'd0, "reset_low0");
    tick(3'd0, "reset_low1");
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick(3'd0, "idle_after_reset");

    // Below-threshold and non-governing inputs must not move L0.
    drive(3'd1, 3'd2, 3'd3, 3'd4);
    for (int i = 0; i < 5; i++) tick(3'd0, "l0_unsat_hold");
    drive(3'd3, 3'd1, 3'd3, 3'd4);
    tick(3'd1, "l0_to_l1");
    tick(3'd2, "l1_to_l2");
    for (int i = 0; i < 5; i++) tick(3'd2, "l2_hold_ns1");

    // L2 -> L4, hold, L4 -> L6, hold, L6 -> L7.
    drive(3'd3, 3'd3, 3'd1, 3'd4);
    tick(3'd3, "l2_to_l3");
    tick(3'd4, "l3_to_l4");
    drive(3'd3, 3'd3, 3'd1, 3'd5);
    for (int i = 0; i < 3; i++) tick(3'd4, "l4_hold_nf1");
    drive(3'd3, 3'd3, 3'd3, 3'd1);
    tick(3'd5, "l4_to_l5");
    tick(3'd6, "l5_to_l6");
    for (int i = 0; i < 3; i++) tick(3'd6, "l6_hold_ne1");
    drive(3'd3, 3'd3, 3'd3, 3'd3);
    tick(3'd7, "l6_to_l7");
    drive(3'd0, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < 3; i++) tick(3'd7, "l7_terminal");

    // Full climb with all needs at 7, then all dropped: L7 sticks.
    async_reset("reset_from_l7");
    drive(3'd7, 3'd7, 3'd7, 3'd7);
    for (int i = 1; i <= 7; i++) tick(i[2:0], "climb_all7");
    drive(3'd0, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < 3; i++) tick(3'd7, "l7_inputs_zero");

    // Transient returns L1->L0, L3->L2, L5->L4.
    async_reset("reset_before_transient");
    drive(3'd3, 3'd0, 3'd0, 3'd0);
    tick(3'd1, "to_l1");
    NH = 3'd2;
    tick(3'd0, "l1_return_l0");
    NH = 3'd3;
    tick(3'd1, "to_l1_again");
    tick(3'd2, "to_l2");
    NH = 3'd0;
    NS = 3'd3;
    tick(3'd3, "to_l3");
    NS = 3'd2;
    tick(3'd2, "l3_return_l2");
    NS = 3'd3;
    tick(3'd3, "to_l3_again");
    tick(3'd4, "to_l4");
    NS = 3'd0;
    NF = 3'd3;
    tick(3'd5, "to_l5");
    NF = 3'd0;
    tick(3'd4, "l5_return_l4");
    NF = 3'd3;
    tick(3'd5, "to_l5_again");
    tick(3'd6, "to_l6");
    NF = 3'd0;
    tick(3'd6, "l6_hold_ne0");

    // Mid-cycle reset in L6 clears before the next edge.
    NE = 3'd7;
    async_reset("reset_in_l6");
    drive(3'd0, 3'd7, 3'd7, 3'd7);
    tick(3'd0, "post_reset_nh0");

    // Reset in transient L3 leaves no partial progress.
    drive(3'd7, 3'd7, 3'd0, 3'd0);
    tick(3'd1, "fast_l1");
    tick(3'd2, "fast_l2");
    tick(3'd3, "fast_l3");
    async_reset("reset_in_l3");
    drive(3'd0, 3'd7, 3'd7, 3'd7);
    tick(3'd0, "no_memory_nh0");
    NH = 3'd3;
    tick(3'd1, "restart_l1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
